async_fifo: RTL and testbench

- Parameterised FIFO buffer with separate write-side and read-side handshakes: push port, pop port, full/empty flags and almost-full/almost-empty flags.
- This revision runs both sides on one clock. Status flags therefore need no cross-domain synchronisers.
- Used between a producer and a consumer block. The test-utility module vlog_tb_utils is bench-only and is not part of this block.

---
 rtl/async_fifo.sv | 75 +++++++
 tb/tb_async_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
//==============================================================================
// Module   : async_fifo
// Brief    : Single-clock FIFO with first-word fall-through read data and
//            full / almost-full / empty / almost-empty status flags.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module async_fifo #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
);

    localparam int DEPTH = 1 << ASIZE;

    // Occupancy values of interest, expressed in pointer width.
    localparam logic [ASIZE:0] c_CNT_FULL  = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] c_CNT_AFULL = {1'b0, {ASIZE{1'b1}}};
    localparam logic [ASIZE:0] c_CNT_ZERO  = {(ASIZE+1){1'b0}};
    localparam logic [ASIZE:0] c_CNT_ONE   = {{ASIZE{1'b0}}, 1'b1};

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [ASIZE:0]   w_count;
    logic             w_push;
    logic             w_pop;

    // Wrap bit makes the modulo difference distinguish full from empty.
    assign w_count = r_wptr - r_rptr;

    assign rempty  = (w_count == c_CNT_ZERO);
    assign wfull   = (w_count == c_CNT_FULL);
    assign awfull  = (w_count == c_CNT_AFULL);
    assign arempty = (w_count == c_CNT_ONE);

    assign w_push  = winc & ~wfull;
    assign w_pop   = rinc & ~rempty;

    assign rdata   = r_mem[r_rptr[ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_CNT_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_CNT_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_async_fifo.sv
//==============================================================================
// Module   : tb_async_fifo
// Brief    : Self-checking bench for async_fifo against a queue reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_async_fifo;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          wfull;
    logic          awfull;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic          rempty;
    logic          arempty;

    int n_checks;
    int n_errors;

    logic [DW-1:0] model_q[$];

    async_fifo #(
        .DSIZE (DW),
        .ASIZE (AW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .winc    (winc),
        .wdata   (wdata),
        .wfull   (wfull),
        .awfull  (awfull),
        .rinc    (rinc),
        .rdata   (rdata),
        .rempty  (rempty),
        .arempty (arempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = model_q.size();
        chk("rempty",  {31'd0, rempty},  {31'd0, sz == 0});
        chk("wfull",   {31'd0, wfull},   {31'd0, sz == DEPTH});
        chk("awfull",  {31'd0, awfull},  {31'd0, sz == DEPTH - 1});
        chk("arempty", {31'd0, arempty}, {31'd0, sz == 1});
        if (sz > 0) begin
            chk("rdata", {16'd0, rdata}, {16'd0, model_q[0]});
        end
    endtask

    // One clock: drive request, apply FIFO rules to the model, then check.
    task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic p);
        logic wr_ok;
        logic rd_ok;
        rst   = r;
        winc  = w;
        wdata = d;
        rinc  = p;
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else begin
            wr_ok = w && (model_q.size() < DEPTH);
            rd_ok = p && (model_q.size() > 0);
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        winc  = 1'b0;
        wdata = '0;
        rinc  = 1'b0;

        // Reset held for several cycles, then idle.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 16'h5555, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("idle_rempty", {31'd0, rempty}, 32'd1);
        chk("idle_wfull",  {31'd0, wfull},  32'd0);

        // Single word round trip.
        step(1'b0, 1'b1, 16'h000A, 1'b0);
        chk("single_rdata", {16'd0, rdata}, 32'h0000_000A);
        chk("single_arempty", {31'd0, arempty}, 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("single_empty", {31'd0, rempty}, 32'd1);

        // Ten words, then continuous read (one extra pop on empty).
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Fill to full, overflow attempt, push+pop while full, drain.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        chk("fill_wfull", {31'd0, wfull}, 32'd1);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Wrap rounds: pointers cross both the address and wrap-bit boundaries.
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0);
            for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, '0, 1'b1);
            chk("round_empty", {31'd0, rempty}, 32'd1);
        end

        // Random traffic with an occasional reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), DW'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 3) == 0), DW'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
